// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//   Shared definitions for the 4x4 matrix keypad emulator.
//   Contents:
//     NUM_ROWS / NUM_COLS / KEY_W  keypad geometry and key-code width
//     ROW_IDLE                     all rows released (active-low lines)
//     LFSR_SEED                    reset value of the contact-bounce LFSR
//     state_e                      emulator FSM states {IDLE, PRESS, GAP}
//     key_row / key_col            field slices of a key code
//     row_drive                    row pattern produced by a closed contact
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned KEY_W    = 4;

    localparam logic [NUM_ROWS-1:0] ROW_IDLE  = 4'hF;
    localparam logic [7:0]          LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_e;

    // key_code[3:2] selects the row, key_code[1:0] the column
    function automatic logic [1:0] key_row(input logic [KEY_W-1:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [KEY_W-1:0] key);
        return key[1:0];
    endfunction

    // A closed switch ties its row to its column: the row reads low only
    // while the scanner drives that column low. Other low columns are
    // irrelevant (wired-AND of the matrix).
    function automatic logic [NUM_ROWS-1:0] row_drive(
        input logic [KEY_W-1:0]    key,
        input logic [NUM_COLS-1:0] cols
    );
        logic [NUM_ROWS-1:0] r;
        r = ROW_IDLE;
        if (cols[key_col(key)] == 1'b0) begin
            r[key_row(key)] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// -----------------------------------------------------------------------------
// bounce_lfsr
//   8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) used to model contact
//   bounce. Advances only while en_i is high; seeded with LFSR_SEED on reset.
//   Only compiled when KEYPAD_EMU_BOUNCE_EN is defined.
//   Ports:
//     clk_i   in  1  clock
//     rst_ni  in  1  asynchronous active-low reset
//     en_i    in  1  advance one step per clock
//     bit_o   out 1  current pseudo-random contact state (1 = closed)
// -----------------------------------------------------------------------------
`ifdef KEYPAD_EMU_BOUNCE_EN
module bounce_lfsr
    import keypad_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic bit_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Taps at stages 8,6,5,4 -> bits 7,5,4,3 when shifting toward the MSB
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[7];

endmodule
`endif

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
//   Emulates a physical 4x4 matrix keypad for one commanded key press at a
//   time: watches the scanner's active-low column strobes and drives the
//   active-low row lines as the pressed switch would.
//   Sequence: IDLE -> PRESS (HOLD_CYCLES) -> GAP (GAP_CYCLES) -> IDLE.
//   Optional: define KEYPAD_EMU_BOUNCE_EN to add contact bounce in the first
//   BOUNCE_CYCLES of PRESS and GAP (LFSR-driven make/break).
//   Ports:
//     clk        in   1  system clock
//     reset      in   1  asynchronous active-low reset
//     key_code   in   4  key to press (row = [3:2], col = [1:0])
//     key_valid  in   1  command valid, taken when key_ready is high
//     key_ready  out  1  idle, command can be accepted
//     shift_col  in   4  scanner column strobes, active-low
//     row        out  4  row lines, active-low, registered
//     busy       out  1  press or gap in progress
//     done       out  1  single-cycle pulse on the last GAP cycle
// -----------------------------------------------------------------------------
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned GAP_CYCLES    = 1000,
    parameter int unsigned BOUNCE_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_W-1:0]    key_code,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [NUM_COLS-1:0] shift_col,
    output logic [NUM_ROWS-1:0] row,
    output logic                busy,
    output logic                done
);

    // Counter sized for the longer phase; the bounce limit is folded in so
    // the window compare is always representable.
    localparam int unsigned PHASE_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX   = (PHASE_MAX > BOUNCE_CYCLES) ? PHASE_MAX : BOUNCE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [NUM_ROWS-1:0] row_q, row_d;
    logic                contact;

    // ------------------------------------------------------------------
    // Contact model: closed for the whole PRESS phase, open otherwise,
    // unless bounce is enabled and we are inside a bounce window.
    // ------------------------------------------------------------------
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(BOUNCE_CYCLES);

    logic in_window;
    logic bounce_bit;

    assign in_window = ((state_q == PRESS) || (state_q == GAP)) && (cnt_q < BOUNCE_LIM);

    bounce_lfsr u_bounce_lfsr (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (in_window),
        .bit_o  (bounce_bit)
    );

    assign contact = in_window ? bounce_bit : (state_q == PRESS);
`else
    assign contact = (state_q == PRESS);
`endif

    // ------------------------------------------------------------------
    // State register (also holds counter, latched key and row register)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            row_q   <= ROW_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            row_q   <= row_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = PRESS;
                    key_d   = key_code;
                end
            end
            PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cleared on every state entry; the phase ends before it can wrap
        if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        key_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == GAP) && (cnt_q == GAP_LAST);
        row_d     = contact ? row_drive(key_q, shift_col) : ROW_IDLE;
    end

    assign row = row_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

    localparam int unsigned HOLD  = 10;
    localparam int unsigned GAP   = 5;
    localparam int unsigned TOTAL = HOLD + GAP;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] key_code  = 4'h0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [3:0] shift_col = 4'hF;
    logic [3:0] row;
    logic       busy;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    keypad_emulator #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .BOUNCE_CYCLES (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .shift_col (shift_col),
        .row       (row),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Physical keypad: key k sits at row k/4, column k%4. The row reads low
    // only if the scanner pulls that key's column low.
    function automatic logic [3:0] model_row(input logic [3:0] key, input logic [3:0] sc);
        int r;
        int c;
        logic [3:0] res;
        r = int'(key) / 4;
        c = int'(key) % 4;
        res = 4'hF;
        if (sc[c] == 1'b0) res[r] = 1'b0;
        return res;
    endfunction

    function automatic logic [3:0] pick_cols(input int mode, input int j);
        logic [3:0] one;
        int sel;
        case (mode)
            1: begin
                if (j <= 3)          return 4'b1101;
                else if (j <= 6)     return 4'b1110;
                else if (j % 2 == 1) return 4'b1101;
                else                 return 4'b0111;
            end
            2: return 4'b0000;
            default: begin
                sel = int'($urandom_range(0, 3));
                one = 4'b0001;
                if ($urandom_range(0, 1) == 1) return ~(one << sel);
                return 4'($urandom_range(0, 15));
            end
        endcase
    endfunction

    // One full press of `key`, starting and ending at a falling edge in IDLE.
    // Cycle j (1..TOTAL) after the accept edge is pressed for j<=HOLD and
    // released otherwise; row seen in cycle j reflects cycle j-1.
    task automatic run_txn(input logic [3:0] key, input int mode,
                           input bit hold_other, input logic [3:0] other);
        logic [3:0] sc;
        logic [3:0] exp_row;
        key_code  = key;
        key_valid = 1'b1;
        shift_col = 4'hF;
        n_cmp++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL txn_ready_pre key=%0d: got %b expected 1", key, key_ready);
        end
        @(posedge clk);
        @(negedge clk);
        key_valid = hold_other;
        key_code  = other;
        exp_row   = 4'hF;
        for (int j = 1; j <= int'(TOTAL); j++) begin
            n_cmp++;
            if (row !== exp_row) begin
                n_fail++;
                $display("FAIL txn_row key=%0d cyc=%0d: got %b expected %b", key, j, row, exp_row);
            end
            n_cmp++;
            if (busy !== 1'b1 || key_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL txn_busy key=%0d cyc=%0d: got busy=%b ready=%b expected busy=1 ready=0",
                         key, j, busy, key_ready);
            end
            n_cmp++;
            if (done !== (j == int'(TOTAL))) begin
                n_fail++;
                $display("FAIL txn_done key=%0d cyc=%0d: got %b expected %b", key, j, done, (j == int'(TOTAL)));
            end
            sc        = pick_cols(mode, j);
            shift_col = sc;
            exp_row   = (j <= int'(HOLD)) ? model_row(key, sc) : 4'hF;
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if (key_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || row !== 4'hF) begin
            n_fail++;
            $display("FAIL txn_end key=%0d: got ready=%b busy=%b done=%b row=%b expected 1 0 0 1111",
                     key, key_ready, busy, done, row);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        shift_col = 4'b0000;
        key_valid = 1'b1;
        key_code  = 4'd5;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (row !== 4'hF || key_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got row=%b ready=%b busy=%b done=%b expected 1111 1 0 0",
                     row, key_ready, busy, done);
        end
        key_valid = 1'b0;
        shift_col = 4'hF;
        reset     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (row !== 4'hF || key_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stable cyc=%0d: got row=%b ready=%b busy=%b done=%b expected 1111 1 0 0",
                         i, row, key_ready, busy, done);
            end
        end
    endtask

    task automatic test_press_key5();
        run_txn(4'd5, 1, 1'b0, 4'd0);
    endtask

    task automatic test_ignore_busy();
        // key 9 is held through the press of key 5 and the done cycle
        run_txn(4'd5, 1, 1'b1, 4'd9);
        run_txn(4'd9, 0, 1'b0, 4'd0);
    endtask

    task automatic test_multicol();
        run_txn(4'd15, 2, 1'b0, 4'd0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] k;
        logic [3:0] nk;
        k = 4'($urandom_range(0, 15));
        for (int i = 0; i < 6; i++) begin
            nk = 4'($urandom_range(0, 15));
            run_txn(k, 0, (i != 5), nk);
            k = nk;
        end
    endtask

    task automatic test_reset_mid_press();
        logic [3:0] sc;
        logic [3:0] one;
        one       = 4'b0001;
        sc        = ~(one << 2);
        key_code  = 4'd6;
        key_valid = 1'b1;
        shift_col = 4'hF;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        shift_col = sc;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if (row !== model_row(4'd6, sc)) begin
            n_fail++;
            $display("FAIL midpress_row: got %b expected %b", row, model_row(4'd6, sc));
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (row !== 4'hF || busy !== 1'b0 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midpress_async: got row=%b busy=%b ready=%b expected 1111 0 1",
                     row, busy, key_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || key_ready !== 1'b1 || row !== 4'hF) begin
                n_fail++;
                $display("FAIL midpress_after cyc=%0d: got done=%b ready=%b row=%b expected 0 1 1111",
                         i, done, key_ready, row);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_key5();
        test_ignore_busy();
        test_multicol();
        test_back_to_back();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
